dds_sample_gen: RTL and testbench

Parametrised sample engine that replaces the fixed tick divider, address counter and ROM chain feeding the DAC/PWM path. It generates a programmable-rate sample strobe and advances a phase accumulator on each strobe. It produces a DATA_W-bit sample in one of four waveform modes (sine via external ROM, sawtooth, triangle, square) with selectable attenuation about mid-scale. `sample` and `sample_valid` drive `spi2dac` (data, load) and `pwm` directly.

---
 rtl/dds_sample_gen.sv | 122 ++++++++++++
 tb/tb_dds_sample_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sample_gen.sv
// dds_sample_gen: programmable-rate sample strobe, phase accumulator and
// four-mode waveform generator with mid-scale attenuation for the DAC/PWM path.
module dds_sample_gen #(
    parameter int DATA_W  = 10,
    parameter int ADDR_W  = 10,
    parameter int PHASE_W = 20,
    parameter int DIV_W   = 16
) (
    input  logic               sysclk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [DIV_W-1:0]   div_val,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [1:0]         mode,
    input  logic [1:0]         atten,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_data,
    output logic               tick,
    output logic [DATA_W-1:0]  sample,
    output logic               sample_valid
);

    typedef enum logic [1:0] {
        MODE_SINE   = 2'b00,
        MODE_SAW    = 2'b01,
        MODE_TRI    = 2'b10,
        MODE_SQUARE = 2'b11
    } mode_e;

    localparam logic [DATA_W:0]   FULL_SCALE = {1'b1, {DATA_W{1'b0}}};
    localparam logic [DATA_W-1:0] MID_SCALE  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   last_cnt;
    logic               tick_q, tick_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               v1_q, v2_q;
    logic [DATA_W:0]    pcap_q, pcap_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic               sample_valid_q;
    logic [DATA_W-1:0]  wave;
    logic [DATA_W-1:0]  tri_base;
    logic [DATA_W:0]    offset;

    // Divider: the >= compare lets a lowered div_val wrap on the next enabled cycle.
    always_comb begin
        last_cnt = (div_val < DIV_W'(2)) ? DIV_W'(1) : div_val - DIV_W'(1);
        tick_d   = 1'b0;
        cnt_d    = cnt_q;
        if (enable) begin
            if (cnt_q >= last_cnt) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (tick_q) begin
            phase_d = phase_q + phase_inc;
        end
    end

    // Only the top DATA_W+1 phase bits feed the waveform shapers.
    always_comb begin
        pcap_d = pcap_q;
        if (v1_q) begin
            pcap_d = phase_q[PHASE_W-1 -: DATA_W+1];
        end
    end

    always_comb begin
        tri_base = pcap_q[DATA_W-1:0];
        case (mode)
            MODE_SINE:   wave = rom_data;
            MODE_SAW:    wave = pcap_q[DATA_W:1];
            MODE_TRI:    wave = pcap_q[DATA_W] ? ~tri_base : tri_base;
            MODE_SQUARE: wave = {DATA_W{pcap_q[DATA_W]}};
            default:     wave = rom_data;
        endcase
    end

    // Attenuated swing is re-centred so that mid-scale stays at mid-scale.
    always_comb begin
        offset   = (FULL_SCALE - (FULL_SCALE >> atten)) >> 1;
        sample_d = sample_q;
        if (v2_q) begin
            sample_d = DATA_W'({1'b0, wave >> atten} + offset);
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            tick_q         <= 1'b0;
            phase_q        <= '0;
            v1_q           <= 1'b0;
            v2_q           <= 1'b0;
            pcap_q         <= '0;
            sample_q       <= MID_SCALE;
            sample_valid_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            tick_q         <= tick_d;
            phase_q        <= phase_d;
            v1_q           <= tick_q;
            v2_q           <= v1_q;
            pcap_q         <= pcap_d;
            sample_q       <= sample_d;
            sample_valid_q <= v2_q;
        end
    end

    assign rom_addr     = phase_q[PHASE_W-1 -: ADDR_W];
    assign tick         = tick_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_dds_sample_gen.sv
// Testbench for dds_sample_gen: scoreboard of expected samples queued at each
// tick and retired at each sample_valid, plus per-feature timing/value tasks.
module tb_dds_sample_gen;

    logic        sysclk;
    logic        rstN;
    logic        enable;
    logic [15:0] divVal;
    logic [19:0] phaseInc;
    logic [1:0]  mode;
    logic [1:0]  atten;
    logic [9:0]  romAddr;
    logic [9:0]  romData;
    logic        tick;
    logic [9:0]  sample;
    logic        sampleValid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [9:0] val;
        int         cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [19:0] mPhase = '0;

    dds_sample_gen #(
        .DATA_W(10), .ADDR_W(10), .PHASE_W(20), .DIV_W(16)
    ) dut (
        .sysclk(sysclk),
        .rst_n(rstN),
        .enable(enable),
        .div_val(divVal),
        .phase_inc(phaseInc),
        .mode(mode),
        .atten(atten),
        .rom_addr(romAddr),
        .rom_data(romData),
        .tick(tick),
        .sample(sample),
        .sample_valid(sampleValid)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Synchronous sine ROM stand-in with an easily recognisable pattern.
    always @(posedge sysclk) begin
        romData <= romAddr ^ 10'h155;
    end

    function automatic logic [9:0] expectSample(input logic [19:0] p, input logic [1:0] m,
                                                input logic [1:0] a);
        int w;
        int top;
        int tbase;
        top   = int'(p >> 10);
        tbase = int'((p >> 9) & 20'h003FF);
        case (m)
            2'd0:    w = top ^ 'h155;
            2'd1:    w = top;
            2'd2:    w = p[19] ? 1023 - tbase : tbase;
            default: w = p[19] ? 1023 : 0;
        endcase
        return 10'((w >> a) + (1024 - (1024 >> a)) / 2);
    endfunction

    // Scoreboard: push on tick, pop and compare on sample_valid.
    always @(negedge sysclk) begin
        exp_t e;
        cyc++;
        if (!rstN) begin
            sbq.delete();
            mPhase = '0;
        end else begin
            if (sampleValid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_unexpected_valid got sample=%0d with no pending tick", sample);
                end else begin
                    e = sbq.pop_front();
                    if (sample !== e.val) begin
                        errors++;
                        $display("[TB] FAIL sb_sample got=%0d exp=%0d", sample, e.val);
                    end
                    checks++;
                    if (cyc - e.cyc !== 3) begin
                        errors++;
                        $display("[TB] FAIL sb_latency got=%0d exp=3", cyc - e.cyc);
                    end
                end
            end
            if (tick) begin
                mPhase = mPhase + phaseInc;
                sbq.push_back('{expectSample(mPhase, mode, atten), cyc});
            end
        end
    end

    task automatic count_to_tick(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge sysclk);
            if (tick) return;
            n++;
        end
    endtask

    task automatic count_to_valid(input int limit, output int n);
        n = 0;
        while (n < limit) begin
            @(negedge sysclk);
            if (sampleValid) return;
            n++;
        end
    endtask

    task automatic do_reset(input logic [15:0] d, input logic [19:0] inc, input logic [1:0] m,
                            input logic [1:0] a, input logic en);
        @(posedge sysclk);
        #1;
        rstN     = 1'b0;
        divVal   = d;
        phaseInc = inc;
        mode     = m;
        atten    = a;
        enable   = en;
        repeat (2) @(posedge sysclk);
        #1 rstN = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        int svCount;
        repeat (2) @(negedge sysclk);
        checks += 4;
        if (tick !== 1'b0) begin errors++; $display("[TB] FAIL rst_tick got=%0b exp=0", tick); end
        if (sampleValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%0b exp=0", sampleValid); end
        if (sample !== 10'd512) begin errors++; $display("[TB] FAIL rst_sample got=%0d exp=512", sample); end
        if (romAddr !== 10'd0) begin errors++; $display("[TB] FAIL rst_addr got=%0d exp=0", romAddr); end

        @(posedge sysclk);
        #1;
        divVal = 16'd4; phaseInc = 20'h00400; mode = 2'b01; atten = 2'd0; enable = 1'b1;
        rstN = 1'b1;
        count_to_tick(20, n);
        count_to_tick(20, n);
        checks++;
        if (n + 1 !== 4) begin errors++; $display("[TB] FAIL rst_pre_period got=%0d exp=4", n + 1); end
        @(posedge sysclk);
        #1;
        checks += 2;
        if (sample !== 10'd1) begin errors++; $display("[TB] FAIL rst_pre_sample got=%0d exp=1", sample); end
        if (romAddr !== 10'd2) begin errors++; $display("[TB] FAIL rst_pre_addr got=%0d exp=2", romAddr); end
        rstN = 1'b0;
        #1;
        checks += 4;
        if (tick !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tick got=%0b exp=0", tick); end
        if (sampleValid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%0b exp=0", sampleValid); end
        if (sample !== 10'd512) begin errors++; $display("[TB] FAIL midrst_sample got=%0d exp=512", sample); end
        if (romAddr !== 10'd0) begin errors++; $display("[TB] FAIL midrst_addr got=%0d exp=0", romAddr); end
        divVal = 16'd10;
        @(posedge sysclk);
        #1 rstN = 1'b1;
        svCount = 0;
        repeat (5) begin
            @(negedge sysclk);
            if (sampleValid) svCount++;
        end
        checks++;
        if (svCount !== 0) begin errors++; $display("[TB] FAIL postrst_valid got=%0d pulses exp=0", svCount); end
    endtask

    task automatic test_saw_rate();
        int n;
        int expNext;
        int svSeen;
        int prev;
        bit wrapped;
        do_reset(16'd5000, 20'h00400, 2'b01, 2'd0, 1'b1);
        count_to_tick(6000, n);
        checks++;
        if (n !== 5000) begin errors++; $display("[TB] FAIL saw_first_tick got=%0d exp=5000", n); end
        repeat (2) begin
            count_to_tick(6000, n);
            checks++;
            if (n + 1 !== 5000) begin errors++; $display("[TB] FAIL saw_period got=%0d exp=5000", n + 1); end
        end
        @(posedge sysclk);
        #1 divVal = 16'd2;
        expNext = 3; svSeen = 0; prev = -1; wrapped = 1'b0;
        for (int i = 0; i < 2300 && svSeen < 1030; i++) begin
            @(negedge sysclk);
            if (sampleValid) begin
                checks++;
                if (sample !== 10'(expNext)) begin
                    errors++;
                    $display("[TB] FAIL saw_value got=%0d exp=%0d", sample, expNext);
                end
                if (prev == 1023 && sample == 10'd0) wrapped = 1'b1;
                prev = int'(sample);
                expNext = (expNext + 1) % 1024;
                svSeen++;
            end
        end
        checks += 2;
        if (svSeen !== 1030) begin errors++; $display("[TB] FAIL saw_count got=%0d exp=1030", svSeen); end
        if (wrapped !== 1'b1) begin errors++; $display("[TB] FAIL saw_wrap got=%0b exp=1", wrapped); end
    endtask

    task automatic test_sine();
        int n;
        do_reset(16'd4, 20'h00400, 2'b00, 2'd0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            count_to_tick(10, n);
            @(negedge sysclk);
            checks++;
            if (romAddr !== 10'(k)) begin errors++; $display("[TB] FAIL sine_addr got=%0d exp=%0d", romAddr, k); end
        end
    endtask

    task automatic test_triangle();
        int n;
        int expVal;
        do_reset(16'd2, 20'h10000, 2'b10, 2'd0, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            count_to_valid(10, n);
            checks++;
            if (n >= 10) begin errors++; $display("[TB] FAIL tri_timeout got=%0d cycles exp=<10", n); end
            expVal = ((k % 16) >= 8) ? 1023 - (k % 8) * 128 : (k % 8) * 128;
            checks++;
            if (sample !== 10'(expVal)) begin errors++; $display("[TB] FAIL tri_value got=%0d exp=%0d", sample, expVal); end
            if (k > 1) begin
                checks++;
                if (n + 1 !== 2) begin errors++; $display("[TB] FAIL tri_gap got=%0d exp=2", n + 1); end
            end
        end
    endtask

    task automatic test_square();
        int n;
        int expVal;
        do_reset(16'd2, 20'h10000, 2'b11, 2'd0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            count_to_valid(10, n);
            expVal = ((k % 16) >= 8) ? 1023 : 0;
            checks++;
            if (sample !== 10'(expVal)) begin errors++; $display("[TB] FAIL sq_value got=%0d exp=%0d", sample, expVal); end
            if (k > 1) begin
                checks++;
                if (n + 1 !== 2) begin errors++; $display("[TB] FAIL sq_gap got=%0d exp=2", n + 1); end
            end
        end
    endtask

    task automatic test_atten();
        int n;
        int expVal;
        bit hi;
        do_reset(16'd20, 20'h10000, 2'b11, 2'd2, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            count_to_valid(40, n);
            checks++;
            if (n >= 40) begin errors++; $display("[TB] FAIL att_timeout got=%0d cycles exp=<40", n); end
            hi = (k % 16) >= 8;
            if (k <= 10) expVal = hi ? 639 : 384;
            else         expVal = hi ? 575 : 448;
            checks++;
            if (sample !== 10'(expVal)) begin errors++; $display("[TB] FAIL att_value k=%0d got=%0d exp=%0d", k, sample, expVal); end
            if (k == 10) begin
                @(posedge sysclk);
                #1 atten = 2'd3;
                @(negedge sysclk);
                checks++;
                if (sample !== 10'd639) begin errors++; $display("[TB] FAIL att_held got=%0d exp=639", sample); end
            end
        end
    endtask

    task automatic test_div_bounds();
        int n;
        for (int d = 0; d <= 1; d++) begin
            do_reset(16'(d), 20'h00400, 2'b01, 2'd0, 1'b1);
            count_to_tick(10, n);
            checks++;
            if (n !== 2) begin errors++; $display("[TB] FAIL div%0d_first got=%0d exp=2", d, n); end
            repeat (2) begin
                count_to_tick(10, n);
                checks++;
                if (n + 1 !== 2) begin errors++; $display("[TB] FAIL div%0d_period got=%0d exp=2", d, n + 1); end
            end
        end
        do_reset(16'd5000, 20'h00400, 2'b01, 2'd0, 1'b1);
        repeat (3000) @(posedge sysclk);
        #1 divVal = 16'd10;
        @(negedge sysclk);
        checks++;
        if (tick !== 1'b0) begin errors++; $display("[TB] FAIL lower_pre got=%0b exp=0", tick); end
        @(negedge sysclk);
        checks++;
        if (tick !== 1'b1) begin errors++; $display("[TB] FAIL lower_next got=%0b exp=1", tick); end
        repeat (2) begin
            count_to_tick(30, n);
            checks++;
            if (n + 1 !== 10) begin errors++; $display("[TB] FAIL lower_period got=%0d exp=10", n + 1); end
        end
    endtask

    task automatic test_enable_hold();
        int n;
        int tickCount;
        int svCount;
        int addrChanges;
        logic [9:0] heldAddr;
        do_reset(16'd10, 20'h00400, 2'b01, 2'd0, 1'b1);
        count_to_tick(30, n);
        @(posedge sysclk);
        #1 enable = 1'b0;
        heldAddr = romAddr;
        tickCount = 0; svCount = 0; addrChanges = 0;
        repeat (100) begin
            @(negedge sysclk);
            if (tick) tickCount++;
            if (sampleValid) svCount++;
            if (romAddr !== heldAddr) addrChanges++;
        end
        checks += 4;
        if (heldAddr !== 10'd1) begin errors++; $display("[TB] FAIL en_addr got=%0d exp=1", heldAddr); end
        if (tickCount !== 0) begin errors++; $display("[TB] FAIL en_ticks got=%0d exp=0", tickCount); end
        if (svCount !== 1) begin errors++; $display("[TB] FAIL en_inflight got=%0d exp=1", svCount); end
        if (addrChanges !== 0) begin errors++; $display("[TB] FAIL en_phase_hold got=%0d changes exp=0", addrChanges); end
        @(posedge sysclk);
        #1 enable = 1'b1;
        count_to_tick(30, n);
        checks++;
        if (n !== 9) begin errors++; $display("[TB] FAIL en_resume got=%0d exp=9", n); end
        @(posedge sysclk);
        #1 phaseInc = 20'h00000;
        svCount = 0;
        repeat (60) begin
            @(negedge sysclk);
            if (sampleValid) begin
                svCount++;
                checks++;
                if (sample !== 10'd2) begin errors++; $display("[TB] FAIL zeroinc_value got=%0d exp=2", sample); end
            end
        end
        checks++;
        if (svCount !== 6) begin errors++; $display("[TB] FAIL zeroinc_count got=%0d exp=6", svCount); end
    endtask

    initial begin
        rstN     = 1'b0;
        enable   = 1'b0;
        divVal   = 16'd0;
        phaseInc = 20'h0;
        mode     = 2'b00;
        atten    = 2'd0;
        test_reset();
        test_saw_rate();
        test_sine();
        test_triangle();
        test_square();
        test_atten();
        test_div_bounds();
        test_enable_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
